// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with a valid/ready output register.
// 16x oversampling, 2-of-3 majority vote per bit, configurable data/stop bits.
// Optional parity checking is compiled in by defining UART_RX_PARITY_EN.
module uart_rx_param #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 ready,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 framing_err,
   output logic                 parity_err,
   output logic                 overrun
);

   // Rounded divisor from system clock to the 16x oversample tick.
   localparam int DIV = (CLK_FREQ + BAUD_RATE * 8) / (BAUD_RATE * 16);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW  = $clog2(DATA_BITS + 1);

   // Elaboration-time parameter legality checks.
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_param: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_rx_param: STOP_BITS must be 1..2");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
      $error("uart_rx_param: PARITY_ODD must be 0 or 1");
   end

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t               state, state_nx;
   logic                 rx_s1, rx_s2, rx_d;
   logic [DW-1:0]        div_cnt;
   logic [3:0]           s_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [1:0]           v;
   logic [DATA_BITS-1:0] sh;
   logic                 brk, fe_acc, done;
   logic                 fall, tick, mid, last, vote, start_go;
`ifdef UART_RX_PARITY_EN
   localparam logic ODD = (PARITY_ODD != 0);
   logic pe_acc;
`endif

   assign fall     = rx_d & ~rx_s2;
   assign tick     = (div_cnt == DW'(DIV - 1));
   assign mid      = tick && (s_cnt == 4'd9);
   assign last     = tick && (s_cnt == 4'd15);
   assign vote     = (v[0] & v[1]) | (v[0] & rx_s2) | (v[1] & rx_s2);
   assign start_go = (state == IDLE) && !brk && fall;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
      end
   end

   // Oversample tick divider, realigned to each detected start edge.
   always_ff @(posedge clock) begin
      if (reset || start_go || tick) div_cnt <= '0;
      else                           div_cnt <= div_cnt + DW'(1);
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic; bits are resolved at tick 9, bit cells end at tick 15.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start_go) state_nx = START;
         START: begin
            if (mid && vote) state_nx = IDLE;
            else if (last)   state_nx = DATA;
         end
         DATA: begin
            if (last && bit_cnt == BW'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
               state_nx = PARITY;
         end
         PARITY: begin
            if (last) state_nx = STOP;
`else
               state_nx = STOP;
`endif
         end
         STOP:  if (mid && bit_cnt == BW'(STOP_BITS - 1)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Sample/bit counters, vote capture, shift register, error accumulation.
   always_ff @(posedge clock) begin
      if (reset) begin
         s_cnt   <= '0;
         bit_cnt <= '0;
         v       <= '0;
         sh      <= '0;
         brk     <= 1'b0;
         fe_acc  <= 1'b0;
         done    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pe_acc  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (brk) begin
               // Break recovery: need 16 consecutive high ticks before re-arming.
               if (!rx_s2) s_cnt <= '0;
               else if (tick) begin
                  if (s_cnt == 4'd15) brk <= 1'b0;
                  s_cnt <= s_cnt + 4'd1;
               end
            end else if (fall) begin
               s_cnt   <= '0;
               bit_cnt <= '0;
               fe_acc  <= 1'b0;
`ifdef UART_RX_PARITY_EN
               pe_acc  <= 1'b0;
`endif
            end
         end else begin
            if (tick) begin
               s_cnt <= s_cnt + 4'd1;
               if (s_cnt == 4'd7) v[0] <= rx_s2;
               if (s_cnt == 4'd8) v[1] <= rx_s2;
            end
            case (state)
               START: if (mid && vote) s_cnt <= '0;
               DATA: begin
                  if (mid) sh <= {vote, sh[DATA_BITS-1:1]};
                  if (last) bit_cnt <= (bit_cnt == BW'(DATA_BITS - 1)) ? '0 : bit_cnt + 1'b1;
               end
`ifdef UART_RX_PARITY_EN
               PARITY: if (mid) pe_acc <= vote ^ (^sh) ^ ODD;
`endif
               STOP: begin
                  if (mid) begin
                     if (!vote) fe_acc <= 1'b1;
                     if (bit_cnt == BW'(STOP_BITS - 1)) begin
                        done    <= 1'b1;
                        brk     <= fe_acc | ~vote;
                        s_cnt   <= '0;
                        bit_cnt <= '0;
                     end
                  end
                  if (last) bit_cnt <= bit_cnt + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // Output register: deliver or drop the completed frame, pulse the flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         data        <= '0;
         valid       <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err  <= 1'b0;
`endif
      end else begin
         framing_err <= 1'b0;
         overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err  <= done & pe_acc;
`endif
         if (done) begin
            framing_err <= fe_acc;
            if (!valid || ready) begin
               data  <= sh;
               valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule
